regfile_port_scheduler: RTL and testbench
=========================================

// Module: regfile_port_scheduler
// PURPOSE
//   Schedules the register file's single write port between two writeback requesters (req0, req1)
//   using round-robin arbitration. Includes a dump sequencer that takes over read port 1 and streams
//   every register out in order, for debug/print. Sits between the writeback stages and the register file.
// PARAMETERS
//   DATA_W    32  register data width
//   ADDR_W    5   register index width
//   NUM_REGS  32  registers walked by a dump (<= 2**ADDR_W)
// PORTS
//   clock          in   1       system clock, rising-edge
//   reset          in   1       synchronous, active-high
//   req0_valid     in   1       requester 0 has a write pending
//   req0_addr      in   ADDR_W  requester 0 destination register
//   req0_data      in   DATA_W  requester 0 write data
//   req0_ready     out  1       requester 0 write accepted this cycle
//   req1_valid     in   1       requester 1 has a write pending
//   req1_addr      in   ADDR_W  requester 1 destination register
//   req1_data      in   DATA_W  requester 1 write data
//   req1_ready     out  1       requester 1 write accepted this cycle
//   dump_start     in   1       single-cycle pulse: begin register dump
//   dump_busy      out  1       dump in progress; write port blocked
//   dump_valid     out  1       dump_addr/dump_data valid this cycle
//   dump_addr      out  ADDR_W  register index being reported
//   dump_data      out  DATA_W  register contents being reported
//   rf_RegWrite    out  1       register-file write enable
//   rf_WriteReg    out  ADDR_W  register-file write index
//   rf_WriteData   out  DATA_W  register-file write data
//   rf_ReadReg1    out  ADDR_W  read port 1 index (owned during dump; 0 otherwise)
//   rf_ReadData1   in   DATA_W  read port 1 data, combinational from rf_ReadReg1
// BEHAVIOUR
//   Reset: all outputs 0. FSM=IDLE. last_grant=1, so req0 wins the first tie. dump index=0.
//   Arbitration (combinational, IDLE only):
//   - Exactly one requester valid -> it is granted.
//   - Both valid -> grant the one not equal to last_grant. last_grant updates on each grant.
//   - Granted reqN_ready=1 in the same cycle. The register file commits at that rising edge.
//   - rf_WriteReg/rf_WriteData = granted addr/data. rf_RegWrite=1 only if granted addr != 0.
//     A write to register 0 is accepted (ready=1) but suppressed (RegWrite=0).
//   - No grant -> rf_RegWrite=0; rf_WriteReg/rf_WriteData=0.
//   FSM: IDLE -> DUMP -> DRAIN -> IDLE.
//   - IDLE: dump_start=1 -> DUMP next cycle, idx=0. Writes granted in this same cycle still commit,
//     so they are included in the snapshot.
//   - DUMP: dump_busy=1; all readys=0; rf_RegWrite=0; rf_ReadReg1=idx.
//     Each edge: capture {idx, rf_ReadData1} into dump_addr/dump_data; dump_valid=1 next cycle; idx++.
//     idx==NUM_REGS-1 -> DRAIN.
//   - DRAIN: dump_busy=1; dump_valid=1 for the last entry -> IDLE.
//   - dump_valid is 0 in every other cycle. dump_addr/dump_data hold their last value.
//   Latency: dump_busy high for NUM_REGS+1 cycles. First dump_valid appears 2 cycles after the
//   dump_start edge. Entries are strictly ascending 0..NUM_REGS-1, one per cycle, with no gaps.
//   Boundaries:
//   - dump_start while busy: ignored.
//   - Requesters held off during a dump keep valid high. Arbitration resumes in the first IDLE
//     cycle, with last_grant preserved.
//   - idx never wraps past NUM_REGS-1.
//   - reset mid-dump: abort; all outputs 0 next cycle; state/last_grant re-initialised.
// TESTING
//   1 req0 only {addr=16, data=0xC}: ready0=1 same cycle, RegWrite=1, WriteReg=16; dump later shows [16]=0xC.
//   2 req0+req1 both valid for 4 cycles, fresh from reset: grants 0,1,0,1; readys never both 1.
//   3 req1 {addr=0, data=8}: ready1=1, rf_RegWrite=0; dump shows [0]=0.
//   4 dump_start after writes [16]=0xC, [17]=8: 32 consecutive dump_valid, addrs 0..31, [16]=0xC, [17]=8, dump_busy 33 cycles.
//   5 req0 valid throughout a dump, plus dump_start pulsed mid-dump: ready0=0 while busy and the
//     pulse is ignored; ready0=1 in the first IDLE cycle.
//   6 reset asserted at dump entry 10: next cycle dump_busy=0, dump_valid=0; a new dump_start restarts from 0.

Source files
------------

// File: rtl/regfile_port_scheduler.sv
// Round-robin scheduler for the register file's write port between two writeback requesters,
// plus a dump sequencer that borrows read port 1 to stream every register out in order.
//
// state   | meaning
// IDLE    | arbitrating writes; dump_start launches a dump
// DUMP    | walking read port 1 over idx, write port blocked
// DRAIN   | last dump entry on the outputs, write port still blocked
module regfile_port_scheduler #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic              dump_start,
  output logic              dump_busy,
  output logic              dump_valid,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              rf_RegWrite,
  output logic [ADDR_W-1:0] rf_WriteReg,
  output logic [DATA_W-1:0] rf_WriteData,
  output logic [ADDR_W-1:0] rf_ReadReg1,
  input  logic [DATA_W-1:0] rf_ReadData1
);

  typedef enum logic [1:0] {S_IDLE, S_DUMP, S_DRAIN} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_t            state, state_nxt;
  logic              last_grant;
  logic [ADDR_W-1:0] idx;
  logic              grant0, grant1;

  always_comb begin
    state_nxt    = state;
    grant0       = 1'b0;
    grant1       = 1'b0;
    rf_RegWrite  = 1'b0;
    rf_WriteReg  = '0;
    rf_WriteData = '0;
    rf_ReadReg1  = '0;
    dump_busy    = 1'b0;
    case (state)
      S_IDLE: begin
        // last_grant==1 means req1 went last, so req0 wins a tie
        grant0 = req0_valid && (!req1_valid || last_grant);
        grant1 = req1_valid && (!req0_valid || !last_grant);
        if (grant0) begin
          rf_WriteReg  = req0_addr;
          rf_WriteData = req0_data;
          rf_RegWrite  = (req0_addr != '0);
        end else if (grant1) begin
          rf_WriteReg  = req1_addr;
          rf_WriteData = req1_data;
          rf_RegWrite  = (req1_addr != '0);
        end
        if (dump_start) state_nxt = S_DUMP;
      end
      S_DUMP: begin
        dump_busy   = 1'b1;
        rf_ReadReg1 = idx;
        if (idx == LAST_IDX) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        dump_busy = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      last_grant <= 1'b1;
      idx        <= '0;
      dump_valid <= 1'b0;
      dump_addr  <= '0;
      dump_data  <= '0;
    end else begin
      state      <= state_nxt;
      dump_valid <= 1'b0;
      if (grant0)      last_grant <= 1'b0;
      else if (grant1) last_grant <= 1'b1;
      if (state == S_IDLE && dump_start) idx <= '0;
      if (state == S_DUMP) begin
        dump_valid <= 1'b1;
        dump_addr  <= idx;
        dump_data  <= rf_ReadData1;
        if (idx != LAST_IDX) idx <= idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_port_scheduler.sv
// Directed bench for regfile_port_scheduler with a behavioural register file behind it.
module tb_regfile_port_scheduler;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_REGS = 32;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              req0_valid = 1'b0, req1_valid = 1'b0, dump_start = 1'b0;
  logic [ADDR_W-1:0] req0_addr = '0, req1_addr = '0;
  logic [DATA_W-1:0] req0_data = '0, req1_data = '0;
  logic              req0_ready, req1_ready, dump_busy, dump_valid, rf_RegWrite;
  logic [ADDR_W-1:0] dump_addr, rf_WriteReg, rf_ReadReg1;
  logic [DATA_W-1:0] dump_data, rf_WriteData, rf_ReadData1;

  logic [DATA_W-1:0] rf_mem [NUM_REGS];

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clock = ~clock;

  regfile_port_scheduler #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .dump_start(dump_start), .dump_busy(dump_busy), .dump_valid(dump_valid),
    .dump_addr(dump_addr), .dump_data(dump_data),
    .rf_RegWrite(rf_RegWrite), .rf_WriteReg(rf_WriteReg), .rf_WriteData(rf_WriteData),
    .rf_ReadReg1(rf_ReadReg1), .rf_ReadData1(rf_ReadData1)
  );

  always @(posedge clock) if (rf_RegWrite) rf_mem[rf_WriteReg] <= rf_WriteData;
  assign rf_ReadData1 = (rf_ReadReg1 == '0) ? '0 : rf_mem[rf_ReadReg1];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  // Runs one dump from a dump_start pulse; records what the bench sees.
  int busy_cnt, valid_cnt, first_valid, addr_err;
  logic [DATA_W-1:0] seen [NUM_REGS];

  task automatic run_dump(input int max_cyc);
    int exp_addr;
    busy_cnt = 0; valid_cnt = 0; first_valid = -1; addr_err = 0; exp_addr = 0;
    dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    for (int cyc = 1; cyc <= max_cyc; cyc++) begin
      if (dump_busy) busy_cnt++;
      if (dump_valid) begin
        if (first_valid < 0) first_valid = cyc;
        if (int'(dump_addr) != exp_addr) addr_err++;
        seen[dump_addr] = dump_data;
        valid_cnt++;
        exp_addr++;
      end
      step();
    end
  endtask

  initial begin
    int ready_busy, wr_busy, cyc;
    bit  found;
    logic exp0;

    for (int i = 0; i < NUM_REGS; i++) rf_mem[i] = '0;
    step(); step();
    reset = 1'b0;
    step();
    chk("rst_busy", dump_busy, 0);
    chk("rst_valid", dump_valid, 0);
    chk("rst_addr", dump_addr, 0);
    chk("rst_data", dump_data, 0);
    chk("rst_regwrite", rf_RegWrite, 0);
    chk("rst_readreg1", rf_ReadReg1, 0);

    // both requesters valid from reset: 0,1,0,1
    req0_valid = 1; req0_addr = 20; req0_data = 32'hA0;
    req1_valid = 1; req1_addr = 21; req1_data = 32'hB1;
    for (int i = 0; i < 4; i++) begin
      #0;
      exp0 = (i % 2 == 0);
      chk($sformatf("rr%0d_ready0", i), req0_ready, exp0);
      chk($sformatf("rr%0d_ready1", i), req1_ready, !exp0);
      chk($sformatf("rr%0d_wreg", i), rf_WriteReg, exp0 ? 20 : 21);
      step();
    end
    req0_valid = 0; req1_valid = 0;
    step();
    chk("idle_regwrite", rf_RegWrite, 0);
    chk("idle_wreg", rf_WriteReg, 0);

    // single requester writes, including a suppressed write to r0
    req0_valid = 1; req0_addr = 16; req0_data = 32'hC;
    #1;
    chk("w16_ready0", req0_ready, 1);
    chk("w16_regwrite", rf_RegWrite, 1);
    chk("w16_wreg", rf_WriteReg, 16);
    chk("w16_wdata", rf_WriteData, 32'hC);
    step();
    req0_valid = 0;
    req1_valid = 1; req1_addr = 0; req1_data = 32'h8;
    #1;
    chk("w0_ready1", req1_ready, 1);
    chk("w0_regwrite", rf_RegWrite, 0);
    step();
    req1_addr = 17;
    #1;
    chk("w17_ready1", req1_ready, 1);
    chk("w17_regwrite", rf_RegWrite, 1);
    step();
    req1_valid = 0;
    step();

    // full dump
    run_dump(40);
    chk("dump_busy_cycles", busy_cnt, NUM_REGS + 1);
    chk("dump_valid_cnt", valid_cnt, NUM_REGS);
    chk("dump_first_valid", first_valid, 2);
    chk("dump_addr_order", addr_err, 0);
    chk("dump_r0", seen[0], 0);
    chk("dump_r16", seen[16], 32'hC);
    chk("dump_r17", seen[17], 32'h8);
    chk("dump_r20", seen[20], 32'hA0);
    chk("dump_r21", seen[21], 32'hB1);
    chk("dump_hold_addr", dump_addr, NUM_REGS - 1);
    chk("dump_after_valid", dump_valid, 0);

    // requester held off by a dump, with a stray dump_start mid-dump
    dump_start = 1;
    step();
    dump_start = 0;
    req0_valid = 1; req0_addr = 18; req0_data = 32'h55;
    busy_cnt = 0; ready_busy = 0; wr_busy = 0; found = 0; cyc = 1;
    while (!found && cyc < 50) begin
      #0;
      if (dump_busy) begin
        busy_cnt++;
        if (req0_ready) ready_busy++;
        if (rf_RegWrite) wr_busy++;
      end else begin
        found = 1;
        chk("hold_idle_ready0", req0_ready, 1);
        chk("hold_idle_wreg", rf_WriteReg, 18);
      end
      dump_start = (cyc == 10);
      if (!found) begin
        step();
        cyc++;
      end
    end
    dump_start = 0;
    chk("hold_idle_reached", found, 1);
    chk("hold_ready_while_busy", ready_busy, 0);
    chk("hold_write_while_busy", wr_busy, 0);
    chk("hold_busy_cycles", busy_cnt, NUM_REGS + 1);
    step();
    req0_valid = 0;
    step();

    // reset partway through a dump
    dump_start = 1;
    step();
    dump_start = 0;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (dump_valid && dump_addr == 10) found = 1;
      else step();
    end
    chk("abort_entry10_seen", found, 1);
    reset = 1;
    step();
    reset = 0;
    chk("abort_busy", dump_busy, 0);
    chk("abort_valid", dump_valid, 0);
    chk("abort_addr", dump_addr, 0);
    chk("abort_data", dump_data, 0);
    req0_valid = 1; req0_addr = 22; req1_valid = 1; req1_addr = 23;
    #1;
    chk("abort_tie_ready0", req0_ready, 1);
    chk("abort_tie_ready1", req1_ready, 0);
    step();
    req0_valid = 0; req1_valid = 0;
    step();
    run_dump(40);
    chk("restart_first_valid", first_valid, 2);
    chk("restart_addr_order", addr_err, 0);
    chk("restart_valid_cnt", valid_cnt, NUM_REGS);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
